// File: rtl/shift_issue_if.sv
// Issue/retire bundle for shift_issue: request, shifter-core link
// and write-back result, with DUT-side and driver-side views.
interface shift_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;

  logic [31:0] sh_numb;
  logic [4:0]  sh_shift;
  logic [1:0]  sh_mode;
  logic [31:0] sh_result;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  modport slave (
    input  in_valid,
    input  in_instr,
    input  in_rs_val,
    input  in_rt_val,
    input  sh_result,
    input  out_ready,
    output in_ready,
    output sh_numb,
    output sh_shift,
    output sh_mode,
    output out_valid,
    output out_result,
    output out_rd,
    output out_illegal
  );

  modport master (
    output in_valid,
    output in_instr,
    output in_rs_val,
    output in_rt_val,
    output sh_result,
    output out_ready,
    input  in_ready,
    input  sh_numb,
    input  sh_shift,
    input  sh_mode,
    input  out_valid,
    input  out_result,
    input  out_rd,
    input  out_illegal
  );
endinterface

// File: rtl/shift_issue.sv
// Two-stage issue/retire wrapper around the MIPS shifter core:
// S1 holds decoded shifter operands, S2 holds the write-back result.
module shift_issue (
  input  logic         clk,
  input  logic         rst,
  shift_issue_if.slave bus
);

  typedef struct packed {
    logic [31:0] numb;
    logic [4:0]  shift;
    logic [1:0]  mode;
    logic [4:0]  rd;
    logic        ill;
  } s1_t;

  s1_t         s1_q;
  s1_t         s1_d;
  s1_t         dec;
  logic        s1_valid_q;
  logic        s1_valid_d;

  logic        s2_valid_q;
  logic        s2_valid_d;
  logic [31:0] res_q;
  logic [31:0] res_d;
  logic [4:0]  rd_q;
  logic [4:0]  rd_d;
  logic        ill_q;
  logic        ill_d;

  logic        accept;
  logic        s1_adv;
  logic        legal;
  logic        rot;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  amt;
  logic [1:0]  mode;
  logic        unused_bits;

  assign op    = bus.in_instr[31:26];
  assign funct = bus.in_instr[5:0];

  assign unused_bits = ^{bus.in_instr[25:22],
                         bus.in_instr[20:16],
                         bus.in_rs_val[31:5]};

  assign s1_adv = s1_valid_q &&
                  (!s2_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid_q || s1_adv;
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    legal = 1'b0;
    if (op == 6'h00) begin
      case (funct)
        6'h00, 6'h02, 6'h03,
        6'h04, 6'h06, 6'h07: legal = 1'b1;
        default:             legal = 1'b0;
      endcase
    end
  end

  // rotr keys off rs[0], rotrv off shamt[0]
  always_comb begin
    rot = 1'b0;
    if (funct == 6'h02) rot = bus.in_instr[21];
    if (funct == 6'h06) rot = bus.in_instr[6];
  end

  assign amt = funct[2] ? bus.in_rs_val[4:0]
                        : bus.in_instr[10:6];

  always_comb begin
    mode = 2'b00;
    unique case (1'b1)
      funct[1:0] == 2'b11: mode = 2'b10;
      funct[1:0] == 2'b10: mode = rot ? 2'b11 : 2'b01;
      default:             mode = 2'b00;
    endcase
  end

  always_comb begin
    dec = '0;
    dec.rd = bus.in_instr[15:11];
    if (legal) begin
      dec.numb  = bus.in_rt_val;
      dec.shift = amt;
      dec.mode  = mode;
    end else begin
      dec.ill = 1'b1;
    end
  end

  // S1 clears when it drains so the core sees zeros while idle
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_d       = dec;
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_d       = '0;
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    rd_d       = rd_q;
    ill_d      = ill_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      res_d      = s1_q.ill ? 32'h0 : bus.sh_result;
      rd_d       = s1_q.rd;
      ill_d      = s1_q.ill;
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      rd_q       <= '0;
      ill_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      rd_q       <= rd_d;
      ill_q      <= ill_d;
    end
  end

  assign bus.sh_numb     = s1_q.numb;
  assign bus.sh_shift    = s1_q.shift;
  assign bus.sh_mode     = s1_q.mode;
  assign bus.out_valid   = s2_valid_q;
  assign bus.out_result  = res_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_illegal = ill_q;

endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue with a behavioural shifter core
// answering the sh_* link.
module tb_shift_issue;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  shift_issue_if bus();

  shift_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] dbl;
  assign dbl = {bus.sh_numb, bus.sh_numb} >> bus.sh_shift;

  always_comb begin
    case (bus.sh_mode)
      2'b00:   bus.sh_result = bus.sh_numb << bus.sh_shift;
      2'b01:   bus.sh_result = bus.sh_numb >> bus.sh_shift;
      2'b10:   bus.sh_result = $signed(bus.sh_numb) >>> bus.sh_shift;
      default: bus.sh_result = dbl[31:0];
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic [4:0] rd,
                                     input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  task automatic run_one(input string       tag,
                         input logic [31:0] instr,
                         input logic [31:0] rs,
                         input logic [31:0] rt,
                         input logic [31:0] e_numb,
                         input logic [4:0]  e_sh,
                         input logic [1:0]  e_md,
                         input logic [31:0] e_res,
                         input logic [4:0]  e_rd,
                         input logic        e_ill);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = instr;
    bus.in_rs_val = rs;
    bus.in_rt_val = rt;
    #1 check({tag, "_rdy"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_instr  = $urandom;
    bus.in_rs_val = $urandom;
    bus.in_rt_val = $urandom;
    #1;
    check({tag, "_s1ov"}, bus.out_valid, 0);
    check({tag, "_numb"}, bus.sh_numb, e_numb);
    check({tag, "_sh"}, bus.sh_shift, e_sh);
    check({tag, "_md"}, bus.sh_mode, e_md);
    @(negedge clk);
    #1;
    check({tag, "_ov"}, bus.out_valid, 1);
    check({tag, "_res"}, bus.out_result, e_res);
    check({tag, "_rd"}, bus.out_rd, e_rd);
    check({tag, "_ill"}, bus.out_illegal, e_ill);
    @(negedge clk);
    #1 check({tag, "_drain"}, bus.out_valid, 0);
  endtask

  logic [31:0] bp_res [4];
  logic [4:0]  bp_rd  [4];
  int          idx;
  int          ret;

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_rs_val = '0;
    bus.in_rt_val = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ov", bus.out_valid, 0);
    check("rst_res", bus.out_result, 0);
    check("rst_rd", bus.out_rd, 0);
    check("rst_ill", bus.out_illegal, 0);
    check("rst_numb", bus.sh_numb, 0);
    check("rst_sh", bus.sh_shift, 0);
    check("rst_md", bus.sh_mode, 0);
    check("rst_rdy", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    run_one("sll", mk(0, 0, 1, 9, 4, 6'h00), 0, 32'h0000_00F1,
            32'h0000_00F1, 4, 2'b00, 32'h0000_0F10, 9, 0);
    run_one("sra", mk(0, 0, 0, 3, 31, 6'h03), 0, 32'h8000_0000,
            32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF, 3, 0);
    run_one("srav", mk(0, 0, 0, 4, 3, 6'h07), 32'h25, 32'hF000_0000,
            32'hF000_0000, 5, 2'b10, 32'hFF80_0000, 4, 0);
    run_one("rotr", mk(0, 1, 0, 5, 1, 6'h02), 0, 32'h1,
            32'h1, 1, 2'b11, 32'h8000_0000, 5, 0);
    run_one("srl", mk(0, 0, 0, 6, 1, 6'h02), 0, 32'h1,
            32'h1, 1, 2'b01, 32'h0, 6, 0);
    run_one("rotrv", mk(0, 0, 0, 7, 1, 6'h06), 4, 32'h1234_5678,
            32'h1234_5678, 4, 2'b11, 32'h8123_4567, 7, 0);
    run_one("srlv", mk(0, 0, 0, 8, 0, 6'h06), 32'hFFFF_FF04,
            32'h1234_5678, 32'h1234_5678, 4, 2'b01,
            32'h0123_4567, 8, 0);
    run_one("sllv", mk(0, 0, 0, 2, 0, 6'h04), 8, 32'hAB,
            32'hAB, 8, 2'b00, 32'hAB00, 2, 0);
    run_one("ill_op", mk(6'h08, 0, 0, 10, 4, 6'h00), 0, 32'hF1,
            0, 0, 2'b00, 0, 10, 1);
    run_one("ill_f20", mk(0, 0, 0, 11, 4, 6'h20), 0, 32'hF1,
            0, 0, 2'b00, 0, 11, 1);
    run_one("ill_f01", mk(0, 0, 0, 12, 4, 6'h01), 0, 32'hF1,
            0, 0, 2'b00, 0, 12, 1);
    run_one("post_ill", mk(0, 0, 0, 14, 8, 6'h00), 0, 32'h1,
            32'h1, 8, 2'b00, 32'h100, 14, 0);

    // backpressure: sll by 1 of 1..4, out_ready low in cycles 2-5
    for (int i = 0; i < 4; i++) begin
      bp_res[i] = 32'(2 * (i + 1));
      bp_rd[i]  = 5'(20 + i);
    end
    idx = 0;
    ret = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 2 && cyc <= 5);
      if (idx < 4) begin
        bus.in_valid  = 1'b1;
        bus.in_instr  = mk(0, 0, 0, 5'(20 + idx), 1, 6'h00);
        bus.in_rt_val = 32'(idx + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        check("bp_acc2", idx, 2);
        check("bp_rdy_lo", bus.in_ready, 0);
      end
      if (cyc == 5) check("bp_rdy_lo5", bus.in_ready, 0);
      if (bus.out_valid) begin
        if (ret < 4) begin
          check("bp_res", bus.out_result, bp_res[ret]);
          check("bp_rd", bus.out_rd, bp_rd[ret]);
        end else begin
          check("bp_extra", bus.out_valid, 0);
        end
        if (bus.out_ready) ret++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    check("bp_ret", ret, 4);
    check("bp_acc", idx, 4);

    // reset with two ops in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk(0, 0, 0, 1, 1, 6'h00);
    bus.in_rt_val = 32'h1;
    @(negedge clk);
    bus.in_instr  = mk(0, 0, 0, 2, 2, 6'h00);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("mid_pre_ov", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_ov", bus.out_valid, 0);
    check("mid_res", bus.out_result, 0);
    check("mid_rd", bus.out_rd, 0);
    check("mid_numb", bus.sh_numb, 0);
    check("mid_rdy", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1 check("mid_rel_ov", bus.out_valid, 0);
    run_one("post_rst", mk(0, 0, 0, 13, 2, 6'h00), 0, 32'h3,
            32'h3, 2, 2'b00, 32'hC, 13, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
